// File: rtl/id_ex_stage_if.sv
// ID-to-EX bus for id_ex_stage: decoded ID inputs, branch/stall controls and EX outputs.
// The optional counter outputs exist only when HAZARD_CNT_EN is defined.
interface id_ex_stage_if #(
  parameter int DW = 32,
  parameter int RW = 5
);
  logic          id_valid;
  logic [5:0]    id_op;
  logic [5:0]    id_func;
  logic [4:0]    id_shamt;
  logic [RW-1:0] id_rs_num;
  logic [RW-1:0] id_rt_num;
  logic [RW-1:0] id_rd_num;
  logic [DW-1:0] id_rs_val;
  logic [DW-1:0] id_rt_val;
  logic [15:0]   id_imm;
  logic          flush;
  logic          ex_hold;
  logic          id_stall;
  logic          ex_valid;
  logic [5:0]    ex_op;
  logic [5:0]    ex_func;
  logic [4:0]    ex_shamt;
  logic [DW-1:0] ex_in1;
  logic [DW-1:0] ex_in2;
  logic [DW-1:0] ex_store_val;
  logic [RW-1:0] ex_dest;
  logic          ex_regwrite;
  logic          ex_memread;
  logic          ex_memwrite;
  logic          ex_illegal;
`ifdef HAZARD_CNT_EN
  logic [15:0]   bubble_cnt;
  logic [15:0]   flush_cnt;
`endif

  modport slave (
    input  id_valid, id_op, id_func, id_shamt, id_rs_num, id_rt_num, id_rd_num,
           id_rs_val, id_rt_val, id_imm, flush, ex_hold,
    output id_stall, ex_valid, ex_op, ex_func, ex_shamt, ex_in1, ex_in2,
           ex_store_val, ex_dest, ex_regwrite, ex_memread, ex_memwrite, ex_illegal
`ifdef HAZARD_CNT_EN
    , output bubble_cnt, flush_cnt
`endif
  );

  modport master (
    output id_valid, id_op, id_func, id_shamt, id_rs_num, id_rt_num, id_rd_num,
           id_rs_val, id_rt_val, id_imm, flush, ex_hold,
    input  id_stall, ex_valid, ex_op, ex_func, ex_shamt, ex_in1, ex_in2,
           ex_store_val, ex_dest, ex_regwrite, ex_memread, ex_memwrite, ex_illegal
`ifdef HAZARD_CNT_EN
    , input bubble_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decodes operands and EX/MEM control, inserts a bubble on load-use.
// Optional HAZARD_CNT_EN adds saturating bubble_cnt / flush_cnt counters.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic         clk,
  input  logic         rst,
  id_ex_stage_if.slave bus
);
  typedef struct packed {
    logic          valid;
    logic [5:0]    op;
    logic [5:0]    func;
    logic [4:0]    shamt;
    logic [DW-1:0] in1;
    logic [DW-1:0] in2;
    logic [DW-1:0] store_val;
    logic [RW-1:0] dest;
    logic          regwrite;
    logic          memread;
    logic          memwrite;
    logic          illegal;
  } ex_t;

  ex_t           r_ex;
  ex_t           w_dec;
  logic          w_is_r;
  logic          w_is_addi;
  logic          w_is_load;
  logic          w_is_sw;
  logic          w_r_ok;
  logic          w_legal;
  logic          w_hazard;
  logic [DW-1:0] w_sext;

  assign w_is_r    = (bus.id_op == 6'h00);
  assign w_is_addi = (bus.id_op == 6'h08);
  assign w_is_load = (bus.id_op == 6'h23) || (bus.id_op == 6'h21) || (bus.id_op == 6'h25);
  assign w_is_sw   = (bus.id_op == 6'h2B);
  assign w_sext    = {{(DW-16){bus.id_imm[15]}}, bus.id_imm};

  always_comb begin
    w_r_ok = 1'b0;
    case (bus.id_func)
      6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h2B, 6'h00, 6'h02: w_r_ok = 1'b1;
      default: w_r_ok = 1'b0;
    endcase
  end

  assign w_legal = (w_is_r && w_r_ok) || w_is_addi || w_is_load || w_is_sw;

  always_comb begin
    w_dec = '0;
    if (bus.id_valid) begin
      w_dec.valid     = 1'b1;
      w_dec.op        = bus.id_op;
      w_dec.func      = bus.id_func;
      w_dec.shamt     = bus.id_shamt;
      w_dec.in1       = bus.id_rs_val;
      w_dec.in2       = w_is_r ? bus.id_rt_val : w_sext;
      w_dec.store_val = bus.id_rt_val;
      w_dec.dest      = w_is_r ? bus.id_rd_num : bus.id_rt_num;
      w_dec.illegal   = !w_legal;
      // Writes to $0 are discarded, so never advertise them downstream.
      w_dec.regwrite  = w_legal && (w_is_r || w_is_addi || w_is_load) && (w_dec.dest != '0);
      w_dec.memread   = w_legal && w_is_load;
      w_dec.memwrite  = w_legal && w_is_sw;
    end
  end

  // rt is only a true source for R-type and sw; for I-type loads/addi it is the destination.
  assign w_hazard = r_ex.valid && r_ex.memread && (r_ex.dest != '0) && bus.id_valid &&
                    ((r_ex.dest == bus.id_rs_num) ||
                     ((r_ex.dest == bus.id_rt_num) && (w_is_r || w_is_sw)));

  assign bus.id_stall = !bus.flush && (w_hazard || bus.ex_hold);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               r_ex <= '0;
    else if (bus.flush)    r_ex <= '0;
    else if (bus.ex_hold)  r_ex <= r_ex;
    else if (w_hazard)     r_ex <= '0;
    else                   r_ex <= w_dec;
  end

  assign bus.ex_valid     = r_ex.valid;
  assign bus.ex_op        = r_ex.op;
  assign bus.ex_func      = r_ex.func;
  assign bus.ex_shamt     = r_ex.shamt;
  assign bus.ex_in1       = r_ex.in1;
  assign bus.ex_in2       = r_ex.in2;
  assign bus.ex_store_val = r_ex.store_val;
  assign bus.ex_dest      = r_ex.dest;
  assign bus.ex_regwrite  = r_ex.regwrite;
  assign bus.ex_memread   = r_ex.memread;
  assign bus.ex_memwrite  = r_ex.memwrite;
  assign bus.ex_illegal   = r_ex.illegal;

`ifdef HAZARD_CNT_EN
  logic [15:0] r_bubble_cnt;
  logic [15:0] r_flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (bus.flush && (r_flush_cnt != 16'hFFFF))
        r_flush_cnt <= r_flush_cnt + 16'd1;
      // Count only bubbles actually inserted by the hazard, not those masked by flush/hold.
      if (!bus.flush && !bus.ex_hold && w_hazard && (r_bubble_cnt != 16'hFFFF))
        r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

  assign bus.bubble_cnt = r_bubble_cnt;
  assign bus.flush_cnt  = r_flush_cnt;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage; define HAZARD_CNT_EN to also check the counters.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_mis = 0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.DW(32), .RW(5)) bus ();
  id_ex_stage #(.DW(32), .RW(5)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic set_id(input logic v, input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] rsv, input logic [31:0] rtv, input logic [15:0] imm);
    bus.id_valid  = v;
    bus.id_op     = op;
    bus.id_func   = fn;
    bus.id_shamt  = 5'd0;
    bus.id_rs_num = rs;
    bus.id_rt_num = rt;
    bus.id_rd_num = rd;
    bus.id_rs_val = rsv;
    bus.id_rt_val = rtv;
    bus.id_imm    = imm;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.flush   = 1'b0;
    bus.ex_hold = 1'b0;
    set_id(1'b1, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 16'h0000);

    // Reset holds the stage empty even with a valid instruction at ID
    step();
    check_eq("rst_valid", bus.ex_valid, 0);
    check_eq("rst_op", bus.ex_op, 0);
    check_eq("rst_func", bus.ex_func, 0);
    check_eq("rst_regwrite", bus.ex_regwrite, 0);
    check_eq("rst_stall", bus.id_stall, 0);
`ifdef HAZARD_CNT_EN
    check_eq("rst_bubble_cnt", bus.bubble_cnt, 0);
    check_eq("rst_flush_cnt", bus.flush_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // add r3,r1,r2
    #1 check_eq("add_stall", bus.id_stall, 0);
    step();
    check_eq("add_valid", bus.ex_valid, 1);
    check_eq("add_op", bus.ex_op, 0);
    check_eq("add_func", bus.ex_func, 32'h20);
    check_eq("add_in1", bus.ex_in1, 5);
    check_eq("add_in2", bus.ex_in2, 7);
    check_eq("add_dest", bus.ex_dest, 3);
    check_eq("add_regwrite", bus.ex_regwrite, 1);

    // addi r4,r1,-3
    set_id(1'b1, 6'h08, 6'h3F, 5'd1, 5'd4, 5'd9, 32'd5, 32'd99, 16'hFFFD);
    step();
    check_eq("addi_in2", bus.ex_in2, 32'hFFFFFFFD);
    check_eq("addi_dest", bus.ex_dest, 4);
    check_eq("addi_regwrite", bus.ex_regwrite, 1);
    check_eq("addi_memread", bus.ex_memread, 0);

    // lw r5,0(r1) followed by add r6,r5,r2
    set_id(1'b1, 6'h23, 6'h00, 5'd1, 5'd5, 5'd0, 32'd100, 32'd0, 16'h0000);
    step();
    check_eq("lw_memread", bus.ex_memread, 1);
    check_eq("lw_dest", bus.ex_dest, 5);
    check_eq("lw_regwrite", bus.ex_regwrite, 1);
    set_id(1'b1, 6'h00, 6'h20, 5'd5, 5'd2, 5'd6, 32'd11, 32'd22, 16'h0000);
    #1 check_eq("hz_stall", bus.id_stall, 1);
    step();
    check_eq("hz_bubble_valid", bus.ex_valid, 0);
    check_eq("hz_bubble_regwrite", bus.ex_regwrite, 0);
    check_eq("hz_stall_drop", bus.id_stall, 0);
    step();
    check_eq("hz_after_valid", bus.ex_valid, 1);
    check_eq("hz_after_dest", bus.ex_dest, 6);
    check_eq("hz_after_in1", bus.ex_in1, 11);
`ifdef HAZARD_CNT_EN
    check_eq("bubble_cnt", bus.bubble_cnt, 1);
`endif

    // lw r0 then use of r0: no stall
    set_id(1'b1, 6'h23, 6'h00, 5'd1, 5'd0, 5'd0, 32'd100, 32'd0, 16'h0008);
    step();
    check_eq("lw0_memread", bus.ex_memread, 1);
    check_eq("lw0_regwrite", bus.ex_regwrite, 0);
    set_id(1'b1, 6'h00, 6'h20, 5'd0, 5'd0, 5'd7, 32'd0, 32'd0, 16'h0000);
    #1 check_eq("lw0_stall", bus.id_stall, 0);
    step();
    check_eq("use0_dest", bus.ex_dest, 7);

    // sw r2,4(r1)
    set_id(1'b1, 6'h2B, 6'h00, 5'd1, 5'd2, 5'd0, 32'd100, 32'h1234, 16'h0004);
    step();
    check_eq("sw_memwrite", bus.ex_memwrite, 1);
    check_eq("sw_regwrite", bus.ex_regwrite, 0);
    check_eq("sw_store_val", bus.ex_store_val, 32'h1234);
    check_eq("sw_in2", bus.ex_in2, 4);

    // ex_hold for 3 cycles while ID keeps changing
    bus.ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 6'h08, 6'h00, 5'd1, 5'(10 + i), 5'd0, 32'd1, 32'd0, 16'(i + 50));
      #1 check_eq("hold_stall", bus.id_stall, 1);
      step();
      check_eq("hold_in2", bus.ex_in2, 4);
      check_eq("hold_memwrite", bus.ex_memwrite, 1);
    end

    // flush together with hold wins
    bus.flush = 1'b1;
    #1 check_eq("flush_stall", bus.id_stall, 0);
    step();
    check_eq("flush_valid", bus.ex_valid, 0);
    check_eq("flush_memwrite", bus.ex_memwrite, 0);
    check_eq("flush_in2", bus.ex_in2, 0);
`ifdef HAZARD_CNT_EN
    check_eq("flush_cnt", bus.flush_cnt, 1);
`endif
    bus.flush   = 1'b0;
    bus.ex_hold = 1'b0;

    // Async reset mid-stall
    set_id(1'b1, 6'h23, 6'h00, 5'd1, 5'd5, 5'd0, 32'd100, 32'd0, 16'h0000);
    step();
    set_id(1'b1, 6'h00, 6'h20, 5'd2, 5'd5, 5'd6, 32'd3, 32'd4, 16'h0000);
    #1 check_eq("pre_rst_stall", bus.id_stall, 1);
    #1 rst = 1'b1;
    #1;
    check_eq("arst_valid", bus.ex_valid, 0);
    check_eq("arst_memread", bus.ex_memread, 0);
    check_eq("arst_dest", bus.ex_dest, 0);
    check_eq("arst_stall", bus.id_stall, 0);
    @(negedge clk);
    rst = 1'b0;
    step();
    check_eq("post_rst_valid", bus.ex_valid, 1);
    check_eq("post_rst_dest", bus.ex_dest, 6);

    // Illegal opcode and illegal R-type funct
    set_id(1'b1, 6'h3F, 6'h00, 5'd1, 5'd8, 5'd0, 32'd1, 32'd2, 16'h0001);
    step();
    check_eq("ill_op_illegal", bus.ex_illegal, 1);
    check_eq("ill_op_valid", bus.ex_valid, 1);
    check_eq("ill_op_ctl", {bus.ex_regwrite, bus.ex_memread, bus.ex_memwrite}, 0);
    set_id(1'b1, 6'h00, 6'h08, 5'd1, 5'd2, 5'd9, 32'd1, 32'd2, 16'h0000);
    step();
    check_eq("ill_fn_illegal", bus.ex_illegal, 1);
    check_eq("ill_fn_regwrite", bus.ex_regwrite, 0);

    // sltu writing $0, then an invalid slot
    set_id(1'b1, 6'h00, 6'h2B, 5'd1, 5'd2, 5'd0, 32'd1, 32'd2, 16'h0000);
    step();
    check_eq("rd0_illegal", bus.ex_illegal, 0);
    check_eq("rd0_regwrite", bus.ex_regwrite, 0);
    set_id(1'b0, 6'h08, 6'h00, 5'd1, 5'd4, 5'd0, 32'd1, 32'd2, 16'h0005);
    step();
    check_eq("inv_valid", bus.ex_valid, 0);
    check_eq("inv_regwrite", bus.ex_regwrite, 0);
    check_eq("inv_in2", bus.ex_in2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline stage that sits directly upstream of the ALU control and the ALU. It registers the decoded instruction from ID and forms the EX-stage operands: in1 = rs value; in2 = rt value for R-type, otherwise the sign-extended immediate.
- Produces the per-instruction control bits for EX and MEM.
- Detects load-use hazards: it inserts one bubble and holds the ID stage.

Parameters:
- DW, 32, datapath width of the operands.
- RW, 5, register-number width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_op  in  6  opcode.
- id_func  in  6  funct field.
- id_shamt  in  5  shift amount.
- id_rs_num  in  RW  rs register number.
- id_rt_num  in  RW  rt register number.
- id_rd_num  in  RW  rd register number.
- id_rs_val  in  DW  register-file rs data.
- id_rt_val  in  DW  register-file rt data.
- id_imm  in  16  immediate field.
- flush  in  1  taken branch: kill the instruction entering EX.
- ex_hold  in  1  downstream stall: freeze EX contents.
- id_stall  out  1  tells PC and IF/ID to hold (combinational).
- ex_valid  out  1  EX holds a real instruction.
- ex_op  out  6  opcode to ALU control.
- ex_func  out  6  funct to ALU control.
- ex_shamt  out  5  shift amount to ALU.
- ex_in1  out  DW  ALU in1.
- ex_in2  out  DW  ALU in2.
- ex_store_val  out  DW  rt data for sw.
- ex_dest  out  RW  destination register number.
- ex_regwrite  out  1  result is written back.
- ex_memread  out  1  instruction is a load.
- ex_memwrite  out  1  instruction is sw.
- ex_illegal  out  1  opcode/funct outside the supported set.

Behaviour:
- Reset (asynchronous, any time): all outputs except id_stall go to 0, i.e. a bubble. id_stall follows its combinational equation, which yields 0 because ex_valid=0.
- Supported set:
  - R-type (op 0) with funct 0x20 (add), 0x22 (sub), 0x24 (and), 0x25 (or), 0x2A (slt), 0x2B (sltu), 0x00 (sll), 0x02 (srl).
  - addi 0x08, lw 0x23, lh 0x21, lhu 0x25, sw 0x2B.
- Decode per instruction:
  - R-type: in2 = rt_val; dest = rd; regwrite = 1.
  - addi, lw, lh, lhu: in2 = sign-extended imm (bit 15 replicated to DW); dest = rt.
  - lw, lh, lhu: memread = 1 and regwrite = 1.
  - addi: regwrite = 1.
  - sw: in2 = sign-extended imm; regwrite = 0; memwrite = 1.
  - ex_store_val = rt_val always.
  - dest = 0 forces regwrite = 0.
- Unsupported op/func: ex_illegal = 1; regwrite, memread and memwrite all 0; ex_valid follows id_valid.
- id_valid = 0: the instruction is loaded as a bubble, with all control bits 0.
- Bubble definition: every output register 0. That is op = 0 / func = 0 (sll $0), regwrite = 0, valid = 0.
- Load-use hazard (combinational) is true when all of the following hold:
  - ex_valid, ex_memread, and ex_dest != 0;
  - id_valid;
  - ex_dest == id_rs_num, or (ex_dest == id_rt_num and ID is R-type or sw).
- id_stall = hazard OR ex_hold, gated to 0 when flush = 1.
- Register update priority each cycle:
  1. rst: bubble.
  2. flush: bubble.
  3. ex_hold: keep all contents.
  4. hazard: bubble, while the ID instruction is held upstream.
  5. otherwise: load the decoded ID instruction.
- Latency: exactly 1 cycle from ID inputs to EX outputs when there is no stall.
- A hazard stalls for exactly one cycle. The bubble clears ex_memread, so the hazard drops on the next cycle and the held instruction then loads.
- flush together with ex_hold: flush wins, and EX becomes a bubble.
- Reset released mid-stall: the stage starts empty and id_stall = 0 in the first cycle.

Optional Feature:
- Macro: HAZARD_CNT_EN.
- When defined:
  - Adds outputs bubble_cnt (16) and flush_cnt (16). Both reset to 0 and saturate at 0xFFFF.
  - bubble_cnt increments on every hazard-inserted bubble.
  - flush_cnt increments on every cycle with flush = 1.
- When undefined: the ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- add r3,r1,r2 with rs_val=5, rt_val=7 -> next cycle ex_op=0, ex_func=0x20, ex_in1=5, ex_in2=7, ex_dest=3, ex_regwrite=1, id_stall=0.
- addi r4,r1,-3 (imm=0xFFFD) -> ex_in2=0xFFFFFFFD, ex_dest=4, ex_regwrite=1, ex_memread=0.
- lw r5,0(r1), then add r6,r5,r2 -> id_stall=1 for one cycle, one bubble (ex_valid=0, ex_regwrite=0), then add loads with ex_dest=6; bubble_cnt=1 if HAZARD_CNT_EN.
- lw r0 followed by a use of r0 -> no stall; sw r2,4(r1) -> ex_memwrite=1, ex_regwrite=0, ex_store_val=rt_val, ex_in2=4.
- ex_hold=1 for 3 cycles while ID changes -> EX outputs unchanged, id_stall=1; flush asserted together with ex_hold -> bubble next edge, id_stall=0.
- rst pulsed asynchronously mid-stream between edges -> all outputs 0 immediately; op=0x3F at ID -> ex_illegal=1, regwrite/memread/memwrite=0.
